// File: rtl/lvt_mem_nw_mr.sv
// lvt_mem_nw_mr: WRITE_PORTS x READ_PORTS register file using a live-value table.
// There is one 1-write/multi-read bank per write port. The LVT records which bank
// holds the newest value for each address. When several ports write the same
// address in one cycle, the highest-numbered port wins the LVT entry. A registered
// flag reports that collision.
// Optional feature: define LVT_MEM_BYPASS_EN to forward same-cycle write data
// onto matching read ports.
module lvt_mem_nw_mr #(
  parameter int WRITE_PORTS = 2,
  parameter int READ_PORTS  = 4,
  parameter int ADDR_WIDTH  = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [WRITE_PORTS-1:0]           we,
  input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] write_addr,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] write_data,
  input  logic [READ_PORTS*ADDR_WIDTH-1:0]  read_addr,
  output logic [READ_PORTS*DATA_WIDTH-1:0]  read_data,
  output logic                             conflict,
  output logic [ADDR_WIDTH-1:0]            conflict_addr
);

  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam int LVT_WIDTH = (WRITE_PORTS > 2) ? $clog2(WRITE_PORTS) : 1;

  logic [DATA_WIDTH-1:0] bank_q [WRITE_PORTS][DEPTH];
  logic [LVT_WIDTH-1:0]  lvt_q  [DEPTH];
  logic                  conflict_q, conflict_d;
  logic [ADDR_WIDTH-1:0] conflict_addr_q, conflict_addr_d;

  logic [ADDR_WIDTH-1:0] waddr [WRITE_PORTS];
  logic [DATA_WIDTH-1:0] wdata [WRITE_PORTS];
  logic [ADDR_WIDTH-1:0] raddr [READ_PORTS];
  logic [DATA_WIDTH-1:0] rdata [READ_PORTS];

  // Unpack the flat write/read buses into per-port views.
  always_comb begin
    for (int p = 0; p < WRITE_PORTS; p++) begin
      waddr[p] = write_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
      wdata[p] = write_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int r = 0; r < READ_PORTS; r++) begin
      raddr[r] = read_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Each bank is written only by its own port. Losing colliders are still stored, but that data is dead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        for (int e = 0; e < DEPTH; e++) begin
          bank_q[p][e] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (we[p]) bank_q[p][waddr[p]] <= wdata[p];
      end
    end
  end

  // LVT update. Ports are visited in ascending order, so the last assignment (the highest port) wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        lvt_q[e] <= '0;
      end
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (we[p]) lvt_q[waddr[p]] <= LVT_WIDTH'(p);
      end
    end
  end

  // Collision detect. The reported address comes from the lowest-numbered colliding port.
  always_comb begin
    conflict_d      = 1'b0;
    conflict_addr_d = conflict_addr_q;
    for (int i = 0; i < WRITE_PORTS; i++) begin
      for (int j = i + 1; j < WRITE_PORTS; j++) begin
        if (!conflict_d && we[i] && we[j] && (waddr[i] == waddr[j])) begin
          conflict_d      = 1'b1;
          conflict_addr_d = waddr[i];
        end
      end
    end
  end

  // Collision flag register. The address is held while the flag is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      conflict_q      <= 1'b0;
      conflict_addr_q <= '0;
    end else begin
      conflict_q      <= conflict_d;
      conflict_addr_q <= conflict_addr_d;
    end
  end

  // Combinational read through the LVT, with optional same-cycle write forwarding.
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      rdata[r] = bank_q[lvt_q[raddr[r]]][raddr[r]];
`ifdef LVT_MEM_BYPASS_EN
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (reset_n && we[p] && (waddr[p] == raddr[r])) rdata[r] = wdata[p];
      end
`endif
    end
  end

  // Repack the per-port read data onto the flat output bus.
  always_comb begin
    read_data = '0;
    for (int r = 0; r < READ_PORTS; r++) begin
      read_data[r*DATA_WIDTH +: DATA_WIDTH] = rdata[r];
    end
  end

  assign conflict      = conflict_q;
  assign conflict_addr = conflict_addr_q;

endmodule
